// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch stage of the 32-bit RISC core.
//   PC_W      : program-counter / instruction-address width
//   RESET_PC  : PC value loaded by reset
//   state_e   : pc_sequencer FSM encoding (visible on the debug state port)
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W = 5;
  localparam logic [PC_W-1:0] RESET_PC = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC selection for the fetch sequencer.
// Priority: jump this cycle > branch this cycle > pending target > pc+1.
// Ports:
//   pc            in  current PC
//   jump          in  jump pulse this cycle
//   jump_target   in  jump destination
//   branch_taken  in  branch pulse this cycle
//   branch_target in  branch destination
//   pend_valid    in  a captured redirect is waiting
//   pend_pc       in  captured redirect destination
//   next_pc       out selected next PC
//   redirect_used out next_pc came from a redirect (fetched word is discarded)
//   wrap          out the increment rolls the PC from all-ones to zero
// ---------------------------------------------------------------------------
module pc_next_sel #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            pend_valid,
  input  logic [PC_W-1:0] pend_pc,
  output logic [PC_W-1:0] next_pc,
  output logic            redirect_used,
  output logic            wrap
);

  logic [PC_W-1:0] pc_inc;

  // Natural modulo-2^PC_W rollover.
  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    next_pc       = pc_inc;
    redirect_used = 1'b1;
    wrap          = 1'b0;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (pend_valid) begin
      next_pc = pend_pc;
    end else begin
      redirect_used = 1'b0;
      // Only a true increment from all-ones counts; a redirect to 0 does not.
      wrap          = &pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage program-counter sequencer. Owns the PC, issues instruction
// memory requests, and applies branch/jump redirects, stall and halt.
//
// Handshake: imem_req is a registered request held high with imem_addr
// stable until imem_ack; an ack edge with imem_req=1 in FETCH completes the
// fetch. imem_ack at any other time is ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall, halt     level controls from the control unit
//   resume          pulse; leave HALT (only when halt is low)
//   branch_taken/branch_target, jump/jump_target   redirect pulses + targets
//   imem_req, imem_addr, imem_ack                  instruction memory port
//   pc              current PC (registered)
//   instr_valid     pulse; word fetched at the previous pc is valid
//   wrap            pulse; PC incremented from all-ones to zero
//   state           FSM state for debug (IDLE=0 FETCH=1 HOLD=2 HALT=3)
// ---------------------------------------------------------------------------
module pc_sequencer
  import cpu_pkg::state_e;
  import cpu_pkg::ST_IDLE;
  import cpu_pkg::ST_FETCH;
  import cpu_pkg::ST_HOLD;
  import cpu_pkg::ST_HALT;
#(
  parameter int                PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0]   RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  output logic            wrap,
  output logic [1:0]      state
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            req_q;
  logic            instr_valid_q;
  logic            wrap_q;
  logic            pend_valid_q;
  logic [PC_W-1:0] pend_pc_q;

  logic [PC_W-1:0] sel_next_pc;
  logic            sel_redirect;
  logic            sel_wrap;

  // Redirect arriving this cycle (jump beats branch).
  logic            redir_now;
  logic [PC_W-1:0] redir_pc;
  // Pending view including a pulse arriving this cycle.
  logic            pend_any;
  logic [PC_W-1:0] pend_any_pc;

  assign redir_now   = jump | branch_taken;
  assign redir_pc    = jump ? jump_target : branch_target;
  assign pend_any    = pend_valid_q | redir_now;
  assign pend_any_pc = redir_now ? redir_pc : pend_pc_q;

  pc_next_sel #(.PC_W(PC_W)) u_next_sel (
    .pc            (pc_q),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pend_valid    (pend_valid_q),
    .pend_pc       (pend_pc_q),
    .next_pc       (sel_next_pc),
    .redirect_used (sel_redirect),
    .wrap          (sel_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      instr_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      wrap_q        <= 1'b0;

      // Capture any redirect; later assignments below may consume/clear it.
      if (redir_now) begin
        pend_valid_q <= 1'b1;
        pend_pc_q    <= redir_pc;
      end

      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end

        ST_FETCH: begin
          if (!req_q) begin
            // One-cycle entry after a pending redirect was loaded into pc.
            req_q <= 1'b1;
          end else if (imem_ack) begin
            pc_q          <= sel_next_pc;
            instr_valid_q <= ~sel_redirect;
            wrap_q        <= sel_wrap;
            if (sel_redirect) begin
              pend_valid_q <= 1'b0;
            end
            if (halt) begin
              state_q <= ST_HALT;
              req_q   <= 1'b0;
            end else if (stall) begin
              state_q <= ST_HOLD;
              req_q   <= 1'b0;
            end
          end
        end

        ST_HOLD, ST_HALT: begin
          if (halt) begin
            state_q <= ST_HALT;
          end else if ((state_q == ST_HOLD) ? !stall : resume) begin
            state_q <= ST_FETCH;
            if (pend_any) begin
              // Apply the redirect before the first request; that fetch is
              // on the correct path, so it is not flushed.
              pc_q         <= pend_any_pc;
              pend_valid_q <= 1'b0;
              req_q        <= 1'b0;
            end else begin
              req_q <= 1'b1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign wrap        = wrap_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       halt;
  logic       resume;
  logic       branch_taken;
  logic [4:0] branch_target;
  logic       jump;
  logic [4:0] jump_target;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic       imem_ack;
  logic [4:0] pc;
  logic       instr_valid;
  logic       wrap;
  logic [1:0] state;

  int total;
  int passed;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(5), .RESET_PC(5'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .halt          (halt),
    .resume        (resume),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .wrap          (wrap),
    .state         (state)
  );

  // ---------------- driver tasks ----------------
  // Advance one active edge and settle; inputs are changed and outputs
  // sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump_ack(input logic [4:0] tgt);
    jump = 1'b1; jump_target = tgt; imem_ack = 1'b1;
    tick();
    jump = 1'b0; imem_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    total++; if (state !== 2'd0) $display("FAIL rst_state got %0d want %0d", state, 0); else passed++;
    total++; if (pc !== 5'd0) $display("FAIL rst_pc got %0d want %0d", pc, 0); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %0b want 0", imem_req); else passed++;
    total++; if (instr_valid !== 1'b0 || wrap !== 1'b0) $display("FAIL rst_pulses got iv=%0b wrap=%0b want 0 0", instr_valid, wrap); else passed++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b1;
    tick();  // IDLE -> FETCH; ack while in IDLE is ignored
    total++; if (state !== 2'd1 || imem_req !== 1'b1 || imem_addr !== 5'd0) $display("FAIL b2b_enter got st=%0d req=%0b addr=%0d want 1 1 0", state, imem_req, imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL b2b_iv0 got %0b want 0", instr_valid); else passed++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (imem_addr !== 5'(i) || instr_valid !== 1'b1 || imem_req !== 1'b1) $display("FAIL b2b_addr%0d got addr=%0d iv=%0b req=%0b want %0d 1 1", i, imem_addr, instr_valid, imem_req, i); else passed++;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_same_cycle_redirect();
    imem_ack = 1'b1;
    tick();
    total++; if (pc !== 5'd4) $display("FAIL redir_pre got %0d want %0d", pc, 4); else passed++;
    jump = 1'b1; jump_target = 5'd20; branch_taken = 1'b1; branch_target = 5'd9;
    tick();
    total++; if (pc !== 5'd20 || instr_valid !== 1'b0) $display("FAIL redir_jump got pc=%0d iv=%0b want 20 0", pc, instr_valid); else passed++;
    jump = 1'b0; branch_taken = 1'b0;
    total++; if (imem_addr !== 5'd20 || imem_req !== 1'b1) $display("FAIL redir_addr got addr=%0d req=%0b want 20 1", imem_addr, imem_req); else passed++;
    tick();
    total++; if (pc !== 5'd21 || instr_valid !== 1'b1) $display("FAIL redir_next got pc=%0d iv=%0b want 21 1", pc, instr_valid); else passed++;
    imem_ack = 1'b0;
  endtask

  task automatic test_slow_ack_pending();
    do_jump_ack(5'd6);
    branch_taken = 1'b1; branch_target = 5'd12;
    tick();
    branch_taken = 1'b0;
    total++; if (pc !== 5'd6 || imem_req !== 1'b1 || instr_valid !== 1'b0) $display("FAIL slow_wait got pc=%0d req=%0b iv=%0b want 6 1 0", pc, imem_req, instr_valid); else passed++;
    tick();
    tick();
    total++; if (imem_addr !== 5'd6) $display("FAIL slow_hold_addr got %0d want %0d", imem_addr, 6); else passed++;
    imem_ack = 1'b1;
    tick();
    total++; if (pc !== 5'd12 || instr_valid !== 1'b0) $display("FAIL slow_ack got pc=%0d iv=%0b want 12 0", pc, instr_valid); else passed++;
    tick();
    total++; if (pc !== 5'd13 || instr_valid !== 1'b1) $display("FAIL slow_cleared got pc=%0d iv=%0b want 13 1", pc, instr_valid); else passed++;
    imem_ack = 1'b0;
  endtask

  task automatic test_stall_halt();
    do_jump_ack(5'd7);
    stall = 1'b1; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (state !== 2'd2 || imem_req !== 1'b0 || pc !== 5'd8 || instr_valid !== 1'b1) $display("FAIL stall_hold got st=%0d req=%0b pc=%0d iv=%0b want 2 0 8 1", state, imem_req, pc, instr_valid); else passed++;
    halt = 1'b1;
    tick();
    total++; if (state !== 2'd3) $display("FAIL halt_enter got %0d want %0d", state, 3); else passed++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    total++; if (state !== 2'd3 || imem_req !== 1'b0) $display("FAIL halt_wins got st=%0d req=%0b want 3 0", state, imem_req); else passed++;
    halt = 1'b0; stall = 1'b0;
    tick();
    total++; if (state !== 2'd3) $display("FAIL halt_wait got %0d want %0d", state, 3); else passed++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    total++; if (state !== 2'd1 || imem_req !== 1'b1 || imem_addr !== 5'd8) $display("FAIL resume got st=%0d req=%0b addr=%0d want 1 1 8", state, imem_req, imem_addr); else passed++;
  endtask

  task automatic test_pending_in_hold();
    stall = 1'b1; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    jump = 1'b1; jump_target = 5'd25;
    tick();
    jump = 1'b0;
    total++; if (state !== 2'd2 || pc !== 5'd9) $display("FAIL hold_redir got st=%0d pc=%0d want 2 9", state, pc); else passed++;
    stall = 1'b0;
    tick();
    total++; if (state !== 2'd1 || imem_req !== 1'b0 || pc !== 5'd25) $display("FAIL hold_exit got st=%0d req=%0b pc=%0d want 1 0 25", state, imem_req, pc); else passed++;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 5'd25) $display("FAIL hold_req got req=%0b addr=%0d want 1 25", imem_req, imem_addr); else passed++;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (pc !== 5'd26 || instr_valid !== 1'b1) $display("FAIL hold_noflush got pc=%0d iv=%0b want 26 1", pc, instr_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_jump_ack(5'd30);
    total++; if (pc !== 5'd30 || wrap !== 1'b0) $display("FAIL wrap_pre got pc=%0d wrap=%0b want 30 0", pc, wrap); else passed++;
    imem_ack = 1'b1;
    tick();
    total++; if (pc !== 5'd31 || wrap !== 1'b0) $display("FAIL wrap_31 got pc=%0d wrap=%0b want 31 0", pc, wrap); else passed++;
    tick();
    total++; if (pc !== 5'd0 || wrap !== 1'b1 || instr_valid !== 1'b1) $display("FAIL wrap_0 got pc=%0d wrap=%0b iv=%0b want 0 1 1", pc, wrap, instr_valid); else passed++;
    tick();
    total++; if (pc !== 5'd1 || wrap !== 1'b0) $display("FAIL wrap_1 got pc=%0d wrap=%0b want 1 0", pc, wrap); else passed++;
    imem_ack = 1'b0;
    do_jump_ack(5'd0);
    total++; if (pc !== 5'd0 || wrap !== 1'b0 || instr_valid !== 1'b0) $display("FAIL wrap_redir0 got pc=%0d wrap=%0b iv=%0b want 0 0 0", pc, wrap, instr_valid); else passed++;
  endtask

  task automatic test_async_reset();
    do_jump_ack(5'd15);
    total++; if (pc !== 5'd15 || imem_req !== 1'b1) $display("FAIL ar_pre got pc=%0d req=%0b want 15 1", pc, imem_req); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || pc !== 5'd0 || state !== 2'd0) $display("FAIL ar_async got req=%0b pc=%0d st=%0d want 0 0 0", imem_req, pc, state); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b1;
    tick();
    total++; if (state !== 2'd1 || pc !== 5'd0 || instr_valid !== 1'b0) $display("FAIL ar_late_ack got st=%0d pc=%0d iv=%0b want 1 0 0", state, pc, instr_valid); else passed++;
    imem_ack = 1'b0;
    tick();
    total++; if (pc !== 5'd0 || imem_req !== 1'b1) $display("FAIL ar_restart got pc=%0d req=%0b want 0 1", pc, imem_req); else passed++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0; passed = 0;
    rst = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    imem_ack = 1'b0;
    test_reset();
    test_back_to_back();
    test_same_cycle_redirect();
    test_slow_ack_pending();
    test_stall_halt();
    test_pending_in_hold();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
